// File: rtl/eth_udp_pkg.sv
// eth_udp_pkg
// Shared definitions for the UDP receive-side port demultiplexer:
//   - state_t     : demux FSM encoding (also exported on the debug port)
//   - UDP_HDR_LEN : size of the UDP header counted by the UDP length field
//   - CH_W        : width of the channel index (covers up to 16 channels)
//   - sat_inc16() : 16-bit increment that sticks at 16'hFFFF
package eth_udp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    localparam logic [15:0] UDP_HDR_LEN = 16'd8;
    localparam int          CH_W        = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eth_udp_rx_port_demux.sv
// eth_udp_rx_port_demux
// Steers one UDP frame (header + byte payload) at a time to one of N_CH
// consumer channels selected by destination port PORT_BASE..PORT_BASE+N_CH-1.
// Frames from a source IP outside the masked filter, or to a port outside the
// window, are consumed and counted. The payload length is reported as
// UDP length - 8, and a last beat whose running byte count disagrees with it
// is flagged on m_axis_user and counted.
//
// Ports:
//   logic_clk, rst_n            clock, asynchronous active-low reset
//   s_udp_hdr_*                 UDP header input (source IP, dest port, length)
//   s_udp_axis_*                payload byte stream input
//   m_hdr_valid/ready[N_CH]     per-channel header handshake
//   m_source_ip, m_length       header fields shared by all channels
//   m_axis_valid/ready[N_CH]    per-channel payload handshake
//   m_axis_data/last/user       payload fields shared by all channels
//   drop_count, len_err_count   saturating status counters
//   dbg_state                   current FSM state (eth_udp_pkg::state_t)
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. Valid never waits on ready; once raised, valid and its data
// are held until that transfer. Ready may depend combinationally on valid.
module eth_udp_rx_port_demux
    import eth_udp_pkg::*;
#(
    parameter int          N_CH      = 4,
    parameter logic [15:0] PORT_BASE = 16'd1234,
    parameter logic [31:0] IP_FILTER = {8'd192, 8'd168, 8'd1, 8'd128},
    parameter logic [31:0] IP_MASK   = 32'hFFFF_FF00
) (
    input  logic              logic_clk,
    input  logic              rst_n,

    input  logic              s_udp_hdr_valid,
    output logic              s_udp_hdr_ready,
    input  logic [31:0]       s_udp_ip_source_ip,
    input  logic [15:0]       s_udp_dest_port,
    input  logic [15:0]       s_udp_length,

    input  logic              s_udp_axis_valid,
    output logic              s_udp_axis_ready,
    input  logic [7:0]        s_udp_axis_data,
    input  logic              s_udp_axis_last,
    input  logic              s_udp_axis_user,

    output logic [N_CH-1:0]   m_hdr_valid,
    input  logic [N_CH-1:0]   m_hdr_ready,
    output logic [31:0]       m_source_ip,
    output logic [15:0]       m_length,

    output logic [N_CH-1:0]   m_axis_valid,
    input  logic [N_CH-1:0]   m_axis_ready,
    output logic [7:0]        m_axis_data,
    output logic              m_axis_last,
    output logic              m_axis_user,

    output logic [15:0]       drop_count,
    output logic [15:0]       len_err_count,
    output logic [1:0]        dbg_state
);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q;
    logic [31:0]       source_ip_q;
    logic [15:0]       length_q;
    logic [15:0]       byte_cnt_q;
    logic [15:0]       drop_cnt_q;
    logic [15:0]       len_err_q;

    logic [N_CH-1:0]   ch_sel;
    logic [16:0]       port_ofs;
    logic              port_in_range;
    logic              ip_match;
    logic              route_ok;
    logic              hdr_fire;
    logic              beat_fire;
    logic              sel_hdr_ready;
    logic              sel_axis_ready;
    logic [15:0]       cnt_next;
    logic              len_mismatch;

    // One 17-bit subtraction gives both the channel index and, through the
    // borrow in bit 16, whether the port lies below PORT_BASE.
    assign port_ofs      = {1'b0, s_udp_dest_port} - {1'b0, PORT_BASE};
    assign port_in_range = !port_ofs[16] && (port_ofs[15:0] < 16'(N_CH));
    assign ip_match      = ((s_udp_ip_source_ip ^ IP_FILTER) & IP_MASK) == 32'd0;
    assign route_ok      = port_in_range && ip_match;

    assign hdr_fire      = s_udp_hdr_valid && s_udp_hdr_ready;
    assign beat_fire     = s_udp_axis_valid && s_udp_axis_ready;
    assign cnt_next      = byte_cnt_q + 16'd1;
    assign len_mismatch  = (cnt_next != length_q);

    always_comb begin
        ch_sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            ch_sel[k] = (ch_q == CH_W'(k));
        end
    end

    assign sel_hdr_ready  = |(m_hdr_ready & ch_sel);
    assign sel_axis_ready = |(m_axis_ready & ch_sel);

    // State register
    always_ff @(posedge logic_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hdr_fire) begin
                    state_d = route_ok ? ST_HDR : ST_DROP;
                end
            end
            ST_HDR: begin
                if (sel_hdr_ready) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD, ST_DROP: begin
                if (beat_fire && s_udp_axis_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        s_udp_hdr_ready  = 1'b0;
        s_udp_axis_ready = 1'b0;
        m_hdr_valid      = '0;
        m_axis_valid     = '0;
        m_axis_user      = s_udp_axis_user;
        case (state_q)
            ST_IDLE: begin
                s_udp_hdr_ready = 1'b1;
            end
            ST_HDR: begin
                m_hdr_valid = ch_sel;
            end
            ST_PAYLOAD: begin
                m_axis_valid     = ch_sel & {N_CH{s_udp_axis_valid}};
                s_udp_axis_ready = sel_axis_ready;
                if (s_udp_axis_last) begin
                    m_axis_user = s_udp_axis_user | len_mismatch;
                end
            end
            ST_DROP: begin
                s_udp_axis_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // Header capture, byte counting and status counters
    always_ff @(posedge logic_clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q        <= '0;
            source_ip_q <= '0;
            length_q    <= '0;
            byte_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            len_err_q   <= '0;
        end else begin
            if (hdr_fire) begin
                source_ip_q <= s_udp_ip_source_ip;
                ch_q        <= port_ofs[CH_W-1:0];
                length_q    <= (s_udp_length < UDP_HDR_LEN) ? 16'd0
                                                            : s_udp_length - UDP_HDR_LEN;
                if (!route_ok) begin
                    drop_cnt_q <= sat_inc16(drop_cnt_q);
                end
            end
            if (state_q == ST_HDR && sel_hdr_ready) begin
                byte_cnt_q <= '0;
            end
            if (state_q == ST_PAYLOAD && beat_fire) begin
                byte_cnt_q <= cnt_next;
                if (s_udp_axis_last && len_mismatch) begin
                    len_err_q <= sat_inc16(len_err_q);
                end
            end
        end
    end

    assign m_source_ip   = source_ip_q;
    assign m_length      = length_q;
    assign m_axis_data   = s_udp_axis_data;
    assign m_axis_last   = s_udp_axis_last;
    assign drop_count    = drop_cnt_q;
    assign len_err_count = len_err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_eth_udp_rx_port_demux.sv
// tb_eth_udp_rx_port_demux
// Directed bench for eth_udp_rx_port_demux with default parameters
// (N_CH=4, ports 1234..1237, source filter 192.168.1.0/24).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Routed payload beats are pushed into exp_q and popped by
// a monitor whenever a channel handshake is seen.
module tb_eth_udp_rx_port_demux;

    localparam int N_CH = 4;

    logic              logic_clk = 1'b0;
    logic              rst_n     = 1'b0;
    logic              s_udp_hdr_valid = 1'b0;
    logic              s_udp_hdr_ready;
    logic [31:0]       s_udp_ip_source_ip = '0;
    logic [15:0]       s_udp_dest_port = '0;
    logic [15:0]       s_udp_length = '0;
    logic              s_udp_axis_valid = 1'b0;
    logic              s_udp_axis_ready;
    logic [7:0]        s_udp_axis_data = '0;
    logic              s_udp_axis_last = 1'b0;
    logic              s_udp_axis_user = 1'b0;
    logic [N_CH-1:0]   m_hdr_valid;
    logic [N_CH-1:0]   m_hdr_ready = '0;
    logic [31:0]       m_source_ip;
    logic [15:0]       m_length;
    logic [N_CH-1:0]   m_axis_valid;
    logic [N_CH-1:0]   m_axis_ready = '1;
    logic [7:0]        m_axis_data;
    logic              m_axis_last;
    logic              m_axis_user;
    logic [15:0]       drop_count;
    logic [15:0]       len_err_count;
    logic [1:0]        dbg_state;

    int          checks = 0;
    int          errors = 0;
    logic [13:0] exp_q[$];   // {channel[3:0], user, last, data[7:0]}
    logic [13:0] mon_e;
    logic        toggle_en = 1'b0;

    eth_udp_rx_port_demux #(.N_CH(N_CH)) dut (
        .logic_clk          (logic_clk),
        .rst_n              (rst_n),
        .s_udp_hdr_valid    (s_udp_hdr_valid),
        .s_udp_hdr_ready    (s_udp_hdr_ready),
        .s_udp_ip_source_ip (s_udp_ip_source_ip),
        .s_udp_dest_port    (s_udp_dest_port),
        .s_udp_length       (s_udp_length),
        .s_udp_axis_valid   (s_udp_axis_valid),
        .s_udp_axis_ready   (s_udp_axis_ready),
        .s_udp_axis_data    (s_udp_axis_data),
        .s_udp_axis_last    (s_udp_axis_last),
        .s_udp_axis_user    (s_udp_axis_user),
        .m_hdr_valid        (m_hdr_valid),
        .m_hdr_ready        (m_hdr_ready),
        .m_source_ip        (m_source_ip),
        .m_length           (m_length),
        .m_axis_valid       (m_axis_valid),
        .m_axis_ready       (m_axis_ready),
        .m_axis_data        (m_axis_data),
        .m_axis_last        (m_axis_last),
        .m_axis_user        (m_axis_user),
        .drop_count         (drop_count),
        .len_err_count      (len_err_count),
        .dbg_state          (dbg_state)
    );

    // Clock
    always #5 logic_clk = ~logic_clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Backpressure pattern on channel 0 payload ready
    always @(posedge logic_clk) begin
        #1;
        if (toggle_en) m_axis_ready[0] = ~m_axis_ready[0];
    end

    // Scoreboard: every channel handshake must match the next expected beat
    always @(negedge logic_clk) begin
        if (rst_n && ((m_axis_valid & m_axis_ready) != '0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_beat: observed valid %b data %0h expected no beat",
                       m_axis_valid, m_axis_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_valid", 32'(m_axis_valid), 32'(4'b0001 << mon_e[13:10]));
                chk("beat_data",  32'(m_axis_data),  32'(mon_e[7:0]));
                chk("beat_last",  32'(m_axis_last),  32'(mon_e[8]));
                chk("beat_user",  32'(m_axis_user),  32'(mon_e[9]));
            end
        end
    end

    // Drivers (called 1 time unit after a rising edge, return likewise)
    task automatic hdr(input logic [31:0] ip, input logic [15:0] port, input logic [15:0] len);
        s_udp_hdr_valid    = 1'b1;
        s_udp_ip_source_ip = ip;
        s_udp_dest_port    = port;
        s_udp_length       = len;
        @(negedge logic_clk);
        chk("hdr_ready", 32'(s_udp_hdr_ready), 1);
        @(posedge logic_clk); #1;
        s_udp_hdr_valid = 1'b0;
    endtask

    task automatic hdr_accept(input logic [3:0] ch);
        m_hdr_ready = '0;
        m_hdr_ready[ch[1:0]] = 1'b1;
        @(negedge logic_clk);
        chk("hdr_valid_onehot", 32'(m_hdr_valid), 32'(4'b0001 << ch));
        @(posedge logic_clk); #1;
        m_hdr_ready = '0;
        @(negedge logic_clk);
        chk("hdr_to_payload", 32'(dbg_state), 2);
        chk("hdr_valid_clear", 32'(m_hdr_valid), 0);
        @(posedge logic_clk); #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic last, input logic user,
                        input logic routed, input logic [3:0] ch, input logic exp_user);
        bit done;
        done = 1'b0;
        if (routed) exp_q.push_back({ch, exp_user, last, d});
        s_udp_axis_valid = 1'b1;
        s_udp_axis_data  = d;
        s_udp_axis_last  = last;
        s_udp_axis_user  = user;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge logic_clk);
            if (routed) begin
                chk("axis_ready_track", 32'(s_udp_axis_ready), 32'(m_axis_ready[ch[1:0]]));
            end else begin
                chk("drop_ready", 32'(s_udp_axis_ready), 1);
                chk("drop_no_valid", 32'({m_axis_valid, m_hdr_valid}), 0);
            end
            done = s_udp_axis_ready;
            @(posedge logic_clk); #1;
        end
        if (!done) chk("beat_timeout", 0, 1);
        s_udp_axis_valid = 1'b0;
        s_udp_axis_last  = 1'b0;
        s_udp_axis_user  = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge logic_clk);
        chk("rst_state",      32'(dbg_state), 0);
        chk("rst_hdr_ready",  32'(s_udp_hdr_ready), 1);
        chk("rst_hdr_valid",  32'(m_hdr_valid), 0);
        chk("rst_axis_valid", 32'(m_axis_valid), 0);
        chk("rst_axis_ready", 32'(s_udp_axis_ready), 0);
        chk("rst_source_ip",  m_source_ip, 0);
        chk("rst_length",     32'(m_length), 0);
        chk("rst_drop",       32'(drop_count), 0);
        chk("rst_len_err",    32'(len_err_count), 0);
        @(posedge logic_clk); #1;
        rst_n = 1'b1;

        // Routed frame: port 1236 -> ch 2, length 13 -> 5 bytes
        hdr(32'hC0A8_0180, 16'd1236, 16'd13);
        @(negedge logic_clk);
        chk("t1_hdr_valid",   32'(m_hdr_valid), 'h4);
        chk("t1_length",      32'(m_length), 5);
        chk("t1_source_ip",   m_source_ip, 32'hC0A8_0180);
        chk("t1_state_hdr",   32'(dbg_state), 1);
        chk("t1_no_axis",     32'(m_axis_valid), 0);
        chk("t1_hold_beats",  32'(s_udp_axis_ready), 0);
        @(posedge logic_clk); #1;
        hdr_accept(4'd2);
        for (int i = 1; i <= 5; i++) beat(8'(i), i == 5, 1'b0, 1'b1, 4'd2, 1'b0);
        @(negedge logic_clk);
        chk("t1_idle",        32'(dbg_state), 0);
        chk("t1_len_err",     32'(len_err_count), 0);
        @(posedge logic_clk); #1;

        // Out-of-range port 1238: dropped, 20 bytes consumed
        hdr(32'hC0A8_0180, 16'd1238, 16'd28);
        @(negedge logic_clk);
        chk("t2_drop_count",  32'(drop_count), 1);
        chk("t2_hdr_valid",   32'(m_hdr_valid), 0);
        chk("t2_state_drop",  32'(dbg_state), 3);
        @(posedge logic_clk); #1;
        for (int i = 0; i < 20; i++) beat(8'(i), i == 19, 1'b0, 1'b0, 4'd0, 1'b0);
        @(negedge logic_clk);
        chk("t2_idle",        32'(dbg_state), 0);
        @(posedge logic_clk); #1;

        // IP filter miss, then a /24 neighbour that passes
        hdr(32'h0A00_0005, 16'd1234, 16'd9);
        @(negedge logic_clk);
        chk("t3_drop_count",  32'(drop_count), 2);
        chk("t3_state_drop",  32'(dbg_state), 3);
        @(posedge logic_clk); #1;
        beat(8'h55, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        hdr(32'hC0A8_0107, 16'd1234, 16'd10);
        @(negedge logic_clk);
        chk("t3_pass_hdr",    32'(m_hdr_valid), 'h1);
        chk("t3_pass_length", 32'(m_length), 2);
        @(posedge logic_clk); #1;
        hdr_accept(4'd0);
        beat(8'hAA, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        beat(8'hBB, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);

        // Length mismatch: length 16 (8 payload bytes) but only 6 sent;
        // beat 3 carries an upstream error which must pass through
        hdr(32'hC0A8_0180, 16'd1235, 16'd16);
        @(negedge logic_clk);
        chk("t4_length",      32'(m_length), 8);
        chk("t4_hdr_valid",   32'(m_hdr_valid), 'h2);
        @(posedge logic_clk); #1;
        hdr_accept(4'd1);
        for (int i = 0; i < 6; i++)
            beat(8'(8'h20 + i), i == 5, i == 2, 1'b1, 4'd1, (i == 2) || (i == 5));
        @(negedge logic_clk);
        chk("t4_len_err",     32'(len_err_count), 1);
        chk("t4_drop_same",   32'(drop_count), 2);
        @(posedge logic_clk); #1;

        // Backpressure: header held 10 cycles, then ready toggles each cycle
        m_axis_ready = '0;
        hdr(32'hC0A8_01FE, 16'd1234, 16'd12);
        for (int i = 0; i < 10; i++) begin
            @(negedge logic_clk);
            chk("t5_hdr_hold",   32'(m_hdr_valid), 'h1);
            chk("t5_len_hold",   32'(m_length), 4);
            chk("t5_ip_hold",    m_source_ip, 32'hC0A8_01FE);
        end
        @(posedge logic_clk); #1;
        toggle_en = 1'b1;
        hdr_accept(4'd0);
        for (int i = 0; i < 4; i++) beat(8'(8'h10 + i), i == 3, 1'b0, 1'b1, 4'd0, 1'b0);
        toggle_en    = 1'b0;
        m_axis_ready = '1;
        @(negedge logic_clk);
        chk("t5_no_loss",     exp_q.size(), 0);
        chk("t5_idle",        32'(dbg_state), 0);
        @(posedge logic_clk); #1;

        // Reset after 3 of 8 bytes; the 4th byte stays waiting upstream
        hdr(32'hC0A8_0180, 16'd1236, 16'd16);
        hdr_accept(4'd2);
        for (int i = 0; i < 3; i++) beat(8'(8'h31 + i), 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        s_udp_axis_valid = 1'b1;
        s_udp_axis_data  = 8'h34;
        rst_n = 1'b0;
        @(negedge logic_clk);
        chk("t6_state",       32'(dbg_state), 0);
        chk("t6_hdr_ready",   32'(s_udp_hdr_ready), 1);
        chk("t6_drop",        32'(drop_count), 0);
        chk("t6_len_err",     32'(len_err_count), 0);
        chk("t6_axis_ready",  32'(s_udp_axis_ready), 0);
        chk("t6_axis_valid",  32'(m_axis_valid), 0);
        chk("t6_length",      32'(m_length), 0);
        @(posedge logic_clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge logic_clk);
            chk("t6_beat_held",  32'(s_udp_axis_ready), 0);
            chk("t6_stay_idle",  32'(dbg_state), 0);
        end
        @(posedge logic_clk); #1;
        s_udp_axis_valid = 1'b0;

        @(negedge logic_clk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
